// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage elastic RV32I/RV64I immediate generator.
// S1 latches instr + decoded format; S2 latches the sign-extended imm.
// Ports:
//   clk, rst              : clock, sync active-high reset
//   in_valid/in_ready     : upstream handshake, instr is the payload
//   out_valid/out_ready   : downstream handshake
//   imm_out/imm_fmt/illegal : registered S2 results
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter bit RV64 = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      imm_fmt,
  output logic            illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  logic            s1_valid_q, s1_valid_d;
  logic [31:7]     s1_ins_q, s1_ins_d;
  logic [2:0]      s1_fmt_q, s1_fmt_d;
  logic            s1_ill_q, s1_ill_d;

  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] s2_imm_q, s2_imm_d;
  logic [2:0]      s2_fmt_q, s2_fmt_d;
  logic            s2_ill_q, s2_ill_d;

  logic            s2_can_load;
  logic            s1_fire;
  logic [6:0]      op;
  logic [2:0]      dec_fmt;
  logic            dec_ill;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_asm;

  assign s2_can_load = !s2_valid_q || out_ready;
  assign in_ready    = !s1_valid_q || s2_can_load;
  assign s1_fire     = in_valid && in_ready;
  assign op          = instr[6:0];

  // All legal opcodes end in 2'b11, so a bad
  // low pair falls through to the default.
  always_comb begin
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    unique case (1'b1)
      (op == 7'b0010011) || (op == 7'b0000011) ||
      (op == 7'b1100111) || (op == 7'b0001111) ||
      (op == 7'b1110011) ||
      (RV64 && op == 7'b0011011):
        dec_fmt = FMT_I;
      (op == 7'b0100011):
        dec_fmt = FMT_S;
      (op == 7'b1100011):
        dec_fmt = FMT_B;
      (op == 7'b0110111) || (op == 7'b0010111):
        dec_fmt = FMT_U;
      (op == 7'b1101111):
        dec_fmt = FMT_J;
      (op == 7'b0110011) ||
      (RV64 && op == 7'b0111011):
        dec_fmt = FMT_NONE;
      default:
        dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    imm32 = 32'h0;
    unique case (s1_fmt_q)
      FMT_I: imm32 = 32'($signed(s1_ins_q[31:20]));
      FMT_S: imm32 = 32'($signed(
               {s1_ins_q[31:25], s1_ins_q[11:7]}));
      FMT_B: imm32 = 32'($signed(
               {s1_ins_q[31], s1_ins_q[7],
                s1_ins_q[30:25], s1_ins_q[11:8],
                1'b0}));
      FMT_U: imm32 = {s1_ins_q[31:12], 12'h0};
      FMT_J: imm32 = 32'($signed(
               {s1_ins_q[31], s1_ins_q[19:12],
                s1_ins_q[20], s1_ins_q[30:21],
                1'b0}));
      default: imm32 = 32'h0;
    endcase
    imm_asm = XLEN'($signed(imm32));
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_ins_d   = s1_ins_q;
    s1_fmt_d   = s1_fmt_q;
    s1_ill_d   = s1_ill_q;
    if (in_ready) s1_valid_d = in_valid;
    if (s1_fire) begin
      s1_ins_d = instr[31:7];
      s1_fmt_d = dec_fmt;
      s1_ill_d = dec_ill;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_imm_d   = s2_imm_q;
    s2_fmt_d   = s2_fmt_q;
    s2_ill_d   = s2_ill_q;
    if (s2_can_load) s2_valid_d = s1_valid_q;
    if (s2_can_load && s1_valid_q) begin
      s2_imm_d = imm_asm;
      s2_fmt_d = s1_fmt_q;
      s2_ill_d = s1_ill_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ins_q   <= '0;
      s1_fmt_q   <= FMT_NONE;
      s1_ill_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_imm_q   <= '0;
      s2_fmt_q   <= FMT_NONE;
      s2_ill_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ins_q   <= s1_ins_d;
      s1_fmt_q   <= s1_fmt_d;
      s1_ill_q   <= s1_ill_d;
      s2_valid_q <= s2_valid_d;
      s2_imm_q   <= s2_imm_d;
      s2_fmt_q   <= s2_fmt_d;
      s2_ill_q   <= s2_ill_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign imm_out   = s2_imm_q;
  assign imm_fmt   = s2_fmt_q;
  assign illegal   = s2_ill_q;

endmodule
